// File: rtl/mem_bank_rsp_buffer_pkg.sv
// Shared width helpers for the bank response buffer and its FIFO.
package mem_bank_rsp_buffer_pkg;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mem_rsp_sync_fifo.sv
// Synchronous FIFO, no fall-through; push and pop in one cycle are both honoured even when full.
module mem_rsp_sync_fifo
  import mem_bank_rsp_buffer_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [DataWidth-1:0] head_o
);
  localparam int unsigned PtrW = ptr_width(Depth);
  localparam int unsigned CntW = cnt_width(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // When full, wr_ptr == rd_ptr: the head is read out this cycle before the slot is overwritten.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_bank_rsp_buffer.sv
// Bridges a fixed-latency SRAM bank (no backpressure) to a valid/ready response stream;
// a credit counter covering in-flight reads plus FIFO occupancy keeps responses from being dropped.
module mem_bank_rsp_buffer
  import mem_bank_rsp_buffer_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned BankLatency = 1,
  parameter int unsigned RspDepth    = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [DataWidth-1:0]   req_wdata_i,
  input  logic [DataWidth/8-1:0] req_be_i,
  output logic                   bank_req_o,
  output logic                   bank_we_o,
  output logic [AddrWidth-1:0]   bank_addr_o,
  output logic [DataWidth-1:0]   bank_wdata_o,
  output logic [DataWidth/8-1:0] bank_be_o,
  input  logic [DataWidth-1:0]   bank_rdata_i,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [DataWidth-1:0]   rdata_o
);
  localparam int unsigned CntW = cnt_width(RspDepth);
  localparam logic [CntW-1:0] DepthCnt = CntW'(RspDepth);

  if (BankLatency < 1) begin : g_bad_latency
    $error("BankLatency must be >= 1");
  end
  if (RspDepth < 1) begin : g_bad_depth
    $error("RspDepth must be >= 1");
  end

  logic [BankLatency-1:0] infl_q, infl_d;
  logic [CntW-1:0]        outst_q, outst_d;
  logic                   rd_acc, pop, push, fifo_full, fifo_empty;

  // Ready depends only on registered credit and the request type, never on rready_i.
  assign req_ready_o  = ~rst_i & (req_we_i | (outst_q < DepthCnt));
  assign bank_req_o   = req_valid_i & req_ready_o;
  assign bank_we_o    = req_we_i;
  assign bank_addr_o  = req_addr_i;
  assign bank_wdata_o = req_wdata_i;
  assign bank_be_o    = req_be_i;

  assign rd_acc   = req_valid_i & ~req_we_i & req_ready_o;
  assign push     = infl_q[BankLatency-1];
  assign rvalid_o = ~fifo_empty & ~rst_i;
  assign pop      = rvalid_o & rready_i;

  always_comb begin
    infl_d  = (infl_q << 1) | BankLatency'(rd_acc);
    outst_d = outst_q;
    case ({rd_acc, pop})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      infl_q  <= '0;
      outst_q <= '0;
    end else begin
      infl_q  <= infl_d;
      outst_q <= outst_d;
    end
  end

  mem_rsp_sync_fifo #(
    .DataWidth (DataWidth),
    .Depth     (RspDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (bank_rdata_i),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (rdata_o)
  );

  a_credit_max: assert property (@(posedge clk_i) disable iff (rst_i) outst_q <= DepthCnt);
  a_credit_min: assert property (@(posedge clk_i) disable iff (rst_i) !(pop && !rd_acc && outst_q == '0));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_mem_bank_rsp_buffer.sv
// Randomized and directed checks of mem_bank_rsp_buffer against a timed response-queue model.
module tb_mem_bank_rsp_buffer;
  localparam int BL  = 2;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_we, rready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, bank_req, bank_we, rvalid;
  logic [31:0] bank_addr, bank_wdata, bank_rdata, rdata;
  logic [3:0]  bank_be;

  always #5 clk = ~clk;

  mem_bank_rsp_buffer #(
    .AddrWidth(32), .DataWidth(32), .BankLatency(BL), .RspDepth(DEP)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_addr_o(bank_addr),
    .bank_wdata_o(bank_wdata), .bank_be_o(bank_be), .bank_rdata_i(bank_rdata),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata)
  );

  // Bank: sparse memory, read data appears BL cycles after the strobe, junk otherwise.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] dly [BL];

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : {16'hA5A5, a[15:0]};
  endfunction

  always @(posedge clk) begin
    dly[0] <= (bank_req && !bank_we) ? rd_mem(bank_addr) : $urandom;
    for (int i = 1; i < BL; i++) dly[i] <= dly[i-1];
  end
  assign bank_rdata = dly[BL-1];

  typedef struct { int due; logic [31:0] data; } rsp_t;
  rsp_t q[$];
  int cyc = 0, cnt = 0, nacc = 0, npop = 0, nrv = 0, last_pop = 0;
  int nchk = 0, nfail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic step(input bit v, input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input bit rr, input bit rs);
    bit exp_rdy, exp_rv, exp_acc, exp_pop;
    logic [31:0] m;
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    rready = rr; rst = rs;
    @(negedge clk);
    exp_rdy = !rs && (we || cnt < DEP);
    exp_rv  = !rs && q.size() > 0 && q[0].due <= cyc;
    chk("req_ready", req_ready, exp_rdy);
    chk("bank_req", bank_req, v && exp_rdy);
    if (v && exp_rdy) begin
      chk("bank_we", bank_we, we);
      chk("bank_addr", bank_addr, a);
      if (we) begin
        chk("bank_wdata", bank_wdata, wd);
        chk("bank_be", bank_be, be);
      end
    end
    chk("rvalid", rvalid, exp_rv);
    if (exp_rv) chk("rdata", rdata, q[0].data);
    if (rvalid === 1'b1) nrv++;
    exp_acc = v && exp_rdy;
    exp_pop = exp_rv && rr;
    if (rs) begin
      q.delete();
      cnt = 0;
    end else begin
      if (exp_pop) begin
        void'(q.pop_front());
        npop++; cnt--; last_pop = cyc;
      end
      if (exp_acc && !we) begin
        q.push_back('{cyc + BL + 1, rd_mem(a)});
        nacc++; cnt++;
      end
      if (exp_acc && we) begin
        m = rd_mem(a);
        for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = wd[8*b +: 8];
        mem[a] = m;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, rr, 0);
  endtask

  task automatic rd(input logic [31:0] a, input bit rr);
    step(1, 0, a, 0, 0, rr, 0);
  endtask

  initial begin
    int base, pbase, fp, fa, n0, p0, c0, rv0, first_pop;
    // Reset state
    step(0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 1, 1);
    idle(1, 1);

    // Single read: exactly one response cycle
    rv0 = nrv;
    rd(32'h1, 1);
    idle(6, 1);
    chk("single_rv_cycles", nrv - rv0, 1);

    // 16 back-to-back reads at full throughput
    base = nacc; pbase = npop; first_pop = -1;
    for (int i = 0; i < 16; i++) begin
      p0 = npop; c0 = cyc;
      rd(32'h10 + i, 1);
      if (npop > p0 && first_pop < 0) first_pop = c0;
    end
    for (int i = 0; i < 6; i++) begin
      p0 = npop; c0 = cyc;
      idle(1, 1);
      if (npop > p0 && first_pop < 0) first_pop = c0;
    end
    chk("b2b_accepted", nacc - base, 16);
    chk("b2b_responses", npop - pbase, 16);
    chk("b2b_consecutive", last_pop - first_pop, 15);

    // Backpressure: credit limits acceptance, resumes one cycle after first pop
    base = nacc;
    for (int i = 0; i < 10; i++) rd(32'h40 + i, 0);
    chk("bp_accepted", nacc - base, DEP);
    fp = -1; fa = -1;
    for (int i = 0; i < 10; i++) begin
      n0 = nacc; p0 = npop; c0 = cyc;
      rd(32'h60 + i, 1);
      if (npop > p0 && fp < 0) fp = c0;
      if (nacc > n0 && fa < 0) fa = c0;
    end
    chk("bp_resume", fa - fp, 1);
    idle(10, 1);

    // Write under full credit, then read back the merged word
    for (int i = 0; i < 6; i++) rd(32'h80 + i, 0);
    base = nacc;
    step(1, 1, 32'h3, 32'hDEADBEEF, 4'b0101, 0, 0);
    rd(32'h90, 0);
    chk("full_read_blocked", nacc - base, 0);
    idle(10, 1);
    rd(32'h3, 1);
    idle(5, 1);

    // Reset with one buffered and two in-flight reads
    rd(32'hA0, 0); rd(32'hA1, 0); rd(32'hA2, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    rv0 = nrv;
    idle(5, 1);
    chk("rst_discard", nrv - rv0, 0);
    pbase = npop;
    rd(32'hB0, 1); rd(32'hB1, 1); rd(32'hB2, 1);
    idle(6, 1);
    chk("rst_new_reads", npop - pbase, 3);

    // Random traffic
    for (int i = 0; i < 10000; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 15),
           $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0);
    idle(10, 1);
    chk("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/mem_bank_rsp_buffer.md
Name: mem_bank_rsp_buffer

Overview:
Sits between a fixed-latency SRAM bank, which has no response backpressure, and the valid/ready response pipeline (the response multicut stage) downstream.
- Forwards requests to the bank.
- Captures each read's data exactly BankLatency cycles after issue into a local FIFO.
- Presents the FIFO as an rvalid/rready/rdata stream.
- A credit counter gates request acceptance so that no read response can ever be dropped.

Parameters:
AddrWidth, 32, bank word address width
DataWidth, 32, data width; byte-enable width is DataWidth/8
BankLatency, 1, cycles from bank_req_o to valid bank_rdata_i; legal range >= 1
RspDepth, 3, response FIFO entries; legal range >= 1; full read throughput requires RspDepth >= BankLatency+2

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_we_i  in  1  1=write, 0=read
req_addr_i  in  AddrWidth  word address
req_wdata_i  in  DataWidth  write data
req_be_i  in  DataWidth/8  byte enables
bank_req_o  out  1  bank access strobe
bank_we_o  out  1  bank write enable
bank_addr_o  out  AddrWidth  bank address
bank_wdata_o  out  DataWidth  bank write data
bank_be_o  out  DataWidth/8  bank byte enables
bank_rdata_i  in  DataWidth  bank read data, valid BankLatency cycles after a read strobe
rvalid_o  out  1  response valid
rready_i  in  1  response ready
rdata_o  out  DataWidth  response data

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - In-flight tracker cleared, FIFO emptied, credit counter = 0.
  - While rst_i is high: req_ready_o=0, bank_req_o=0, rvalid_o=0.
  - Reset mid-operation silently discards all in-flight and buffered reads.
- Request path is combinational:
  - bank_req_o = req_valid_i & req_ready_o.
  - bank_we/addr/wdata/be = req_* unmodified.
- Writes:
  - req_ready_o for a write = ~rst_i (always accepted).
  - Consume no credit, produce no response.
- Reads:
  - req_ready_o = ~rst_i & (outstanding < RspDepth).
  - outstanding is a register counting in-flight reads plus FIFO occupancy, width $clog2(RspDepth+1).
  - req_ready_o depends only on registered state and req_we_i; there is no combinational path from rready_i.
- In-flight tracking:
  - Shift register of BankLatency bits; stage 0 is loaded with (accepted read) each cycle.
  - When the final stage bit is 1, bank_rdata_i is pushed into the FIFO in that cycle.
- FIFO:
  - Synchronous, no fall-through. rvalid_o = ~empty; rdata_o = head.
  - Pop on rvalid_o & rready_i.
  - Push and pop in the same cycle are both honoured, including when full.
  - The credit scheme guarantees a push never occurs when full and no pop is happening; this is an assertion.
- Latency:
  - Read accepted in cycle t, data captured at end of cycle t+BankLatency, rvalid_o high from cycle t+BankLatency+1.
  - Responses are delivered in request order.
- Counter:
  - outstanding_next = outstanding + (read accepted) - (pop).
  - Simultaneous accept and pop leaves the counter unchanged.
  - A pop frees its credit the following cycle.
- rvalid_o/rdata_o hold stable while rvalid_o & ~rready_i.
- Assertions:
  - Counter never exceeds RspDepth and never underflows.
  - No FIFO overflow.
  - Elaboration error if BankLatency==0 or RspDepth==0.

Decomposition:
- No shared package types are required.
- Count width and FIFO pointer width are local parameters derived from RspDepth.
- One natural sub-module, mem_rsp_sync_fifo (DataWidth, Depth; synchronous active-high reset; push/pop/full/empty/head).
- The tracker and credit counter stay in the top module.

Test Plan:
- Single read, BankLatency=1, RspDepth=3, rready_i=1: read accepted cycle 0, bank returns 0xA5A5_0001 in cycle 1 -> rvalid_o=1 with rdata_o=0xA5A5_0001 in cycle 2 only.
- Back-to-back reads, BankLatency=2, RspDepth=4, rready_i=1: 16 consecutive reads -> req_ready_o never drops, 16 responses in order on 16 consecutive cycles starting cycle 3.
- Backpressure, RspDepth=3, BankLatency=1, rready_i=0: reads issued continuously -> exactly 3 accepted, req_ready_o=0 for reads thereafter. Raise rready_i -> 3 responses in order; acceptance resumes one cycle after the first pop.
- Writes under full credit: counter at RspDepth, issue a write -> accepted immediately, bank_we_o=1 and bank_be_o passed through, no response generated, counter unchanged.
- Reset mid-operation: 2 reads in flight and 1 buffered, assert rst_i one cycle -> next cycle rvalid_o=0, counter 0, old bank_rdata_i not captured; 3 new reads complete normally.
- Random rready_i (50%) with a random read/write mix over 10k cycles, checked against a scoreboard -> every read returns matching data in order, with no assertion firing.
